// File: rtl/rx_destuff.sv
// CAN receive bit destuffer: removes stuff bits, forwards data bits to the shift
// register, flags stuff errors and counts destuffed bits.
module rx_destuff #(
    parameter int unsigned STUFFLEN = 5,
    parameter int unsigned CNTW     = 7
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            sample,
    input  logic            rxbit,
    input  logic            destuff_en,
    output logic            bitout,
    output logic            actvout,
    output logic            stuffbit,
    output logic            stufferr,
    output logic [CNTW-1:0] bitcnt
);

    localparam int unsigned RW = $clog2(STUFFLEN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(STUFFLEN);
    localparam logic [RW-1:0] RUN_ONE = RW'(1);

    logic [RW-1:0] runlen;
    logic          lastbit;

    always_ff @(posedge clock) begin
        if (reset) begin
            bitout   <= 1'b1;
            actvout  <= 1'b0;
            stuffbit <= 1'b0;
            stufferr <= 1'b0;
            bitcnt   <= '0;
            runlen   <= '0;
            lastbit  <= 1'b1;
        end else if (!destuff_en) begin
            // bitout and lastbit hold; runlen=0 already discards the history
            actvout  <= 1'b0;
            stuffbit <= 1'b0;
            stufferr <= 1'b0;
            bitcnt   <= '0;
            runlen   <= '0;
        end else begin
            actvout  <= 1'b0;
            stuffbit <= 1'b0;
            if (sample && !stufferr) begin
                if (runlen == RUN_MAX) begin
                    if (rxbit != lastbit) begin
                        stuffbit <= 1'b1;
                        runlen   <= RUN_ONE;
                        lastbit  <= rxbit;
                    end else begin
                        stufferr <= 1'b1;
                    end
                end else begin
                    bitout  <= rxbit;
                    actvout <= 1'b1;
                    lastbit <= rxbit;
                    if (rxbit == lastbit && runlen != '0)
                        runlen <= runlen + RUN_ONE;
                    else
                        runlen <= RUN_ONE;
                    if (bitcnt != '1)
                        bitcnt <= bitcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_destuff.sv
// Directed self-checking bench for rx_destuff with hand-computed expectations.
module tb_rx_destuff;

    logic       clock;
    logic       reset;
    logic       sample;
    logic       rxbit;
    logic       destuff_en;
    logic       bitout;
    logic       actvout;
    logic       stuffbit;
    logic       stufferr;
    logic [6:0] bitcnt;

    int nvec;
    int nerr;

    rx_destuff #(.STUFFLEN(5), .CNTW(7)) dut (
        .clock     (clock),
        .reset     (reset),
        .sample    (sample),
        .rxbit     (rxbit),
        .destuff_en(destuff_en),
        .bitout    (bitout),
        .actvout   (actvout),
        .stuffbit  (stuffbit),
        .stufferr  (stufferr),
        .bitcnt    (bitcnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One sample strobe; on return the registered response is visible
    task automatic send(input logic b);
        sample = 1'b1;
        rxbit  = b;
        tick();
        sample = 1'b0;
    endtask

    task automatic clear_hist();
        destuff_en = 1'b0;
        tick();
        destuff_en = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        destuff_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample = (i % 2 == 0);
            rxbit  = (i % 3 == 0);
            tick();
        end
        sample = 1'b0;
        nvec++; if (bitout !== 1'b1) begin nerr++; $display("FAIL reset_bitout: got %b expected 1", bitout); end
        nvec++; if (actvout !== 1'b0) begin nerr++; $display("FAIL reset_actvout: got %b expected 0", actvout); end
        nvec++; if (stufferr !== 1'b0) begin nerr++; $display("FAIL reset_stufferr: got %b expected 0", stufferr); end
        nvec++; if (stuffbit !== 1'b0) begin nerr++; $display("FAIL reset_stuffbit: got %b expected 0", stuffbit); end
        nvec++; if (bitcnt !== 7'd0) begin nerr++; $display("FAIL reset_bitcnt: got %0d expected 0", bitcnt); end
        reset = 1'b0;
        send(1'b0);
        nvec++; if (actvout !== 1'b1) begin nerr++; $display("FAIL sof_actvout: got %b expected 1", actvout); end
        nvec++; if (bitout !== 1'b0) begin nerr++; $display("FAIL sof_bitout: got %b expected 0", bitout); end
        nvec++; if (bitcnt !== 7'd1) begin nerr++; $display("FAIL sof_bitcnt: got %0d expected 1", bitcnt); end
        tick();
        nvec++; if (actvout !== 1'b0) begin nerr++; $display("FAIL sof_actvout_pulse: got %b expected 0", actvout); end
    endtask

    task automatic test_stuff_removal();
        logic [6:0] pat;
        pat = 7'b0100000; // bit i is the i-th sample, LSB first: 0,0,0,0,0,1,0
        clear_hist();
        for (int i = 0; i < 7; i++) begin
            send(pat[i]);
            if (i == 5) begin
                nvec++; if (stuffbit !== 1'b1) begin nerr++; $display("FAIL removal_stuffbit: got %b expected 1", stuffbit); end
                nvec++; if (actvout !== 1'b0) begin nerr++; $display("FAIL removal_stuff_actv: got %b expected 0", actvout); end
                nvec++; if (bitout !== 1'b0) begin nerr++; $display("FAIL removal_stuff_bitout: got %b expected 0", bitout); end
            end else begin
                nvec++; if (actvout !== 1'b1) begin nerr++; $display("FAIL removal_actv bit%0d: got %b expected 1", i + 1, actvout); end
                nvec++; if (stuffbit !== 1'b0) begin nerr++; $display("FAIL removal_nostuff bit%0d: got %b expected 0", i + 1, stuffbit); end
            end
            tick();
            nvec++; if (stuffbit !== 1'b0 || actvout !== 1'b0) begin nerr++; $display("FAIL removal_pulse bit%0d: got stuff=%b actv=%b expected 0 0", i + 1, stuffbit, actvout); end
            repeat (6) tick();
        end
        nvec++; if (bitcnt !== 7'd6) begin nerr++; $display("FAIL removal_bitcnt: got %0d expected 6", bitcnt); end
        nvec++; if (bitout !== 1'b0) begin nerr++; $display("FAIL removal_bitout: got %b expected 0", bitout); end
    endtask

    task automatic test_stuff_error();
        clear_hist();
        for (int i = 0; i < 5; i++) begin
            send(1'b1);
            nvec++; if (actvout !== 1'b1) begin nerr++; $display("FAIL err_actv bit%0d: got %b expected 1", i + 1, actvout); end
        end
        send(1'b1);
        nvec++; if (stufferr !== 1'b1) begin nerr++; $display("FAIL err_flag: got %b expected 1", stufferr); end
        nvec++; if (actvout !== 1'b0) begin nerr++; $display("FAIL err_actv6: got %b expected 0", actvout); end
        nvec++; if (bitcnt !== 7'd5) begin nerr++; $display("FAIL err_bitcnt: got %0d expected 5", bitcnt); end
        send(1'b0);
        nvec++; if (actvout !== 1'b0 || stuffbit !== 1'b0) begin nerr++; $display("FAIL err_ignored: got actv=%b stuff=%b expected 0 0", actvout, stuffbit); end
        nvec++; if (bitout !== 1'b1 || bitcnt !== 7'd5 || stufferr !== 1'b1) begin nerr++; $display("FAIL err_hold: got bitout=%b cnt=%0d err=%b expected 1 5 1", bitout, bitcnt, stufferr); end
        clear_hist();
        nvec++; if (stufferr !== 1'b0) begin nerr++; $display("FAIL err_clear_flag: got %b expected 0", stufferr); end
        nvec++; if (bitcnt !== 7'd0) begin nerr++; $display("FAIL err_clear_cnt: got %0d expected 0", bitcnt); end
    endtask

    task automatic test_chained();
        int npulse;
        logic [10:0] pat;
        npulse = 0;
        pat = 11'b01111100000; // 0x5, 1 (stuff), 1x4, 0 (stuff), LSB first
        clear_hist();
        for (int i = 0; i < 11; i++) begin
            send(pat[i]);
            if (stuffbit === 1'b1) npulse++;
            tick();
        end
        nvec++; if (npulse != 2) begin nerr++; $display("FAIL chain_pulses: got %0d expected 2", npulse); end
        nvec++; if (bitcnt !== 7'd9) begin nerr++; $display("FAIL chain_bitcnt: got %0d expected 9", bitcnt); end
        nvec++; if (stufferr !== 1'b0) begin nerr++; $display("FAIL chain_stufferr: got %b expected 0", stufferr); end
        nvec++; if (bitout !== 1'b1) begin nerr++; $display("FAIL chain_bitout: got %b expected 1", bitout); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] pat;
        pat = 3'b101;
        clear_hist();
        sample = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rxbit = pat[i];
            tick();
            nvec++; if (actvout !== 1'b1) begin nerr++; $display("FAIL b2b_actv%0d: got %b expected 1", i, actvout); end
            nvec++; if (bitout !== pat[i]) begin nerr++; $display("FAIL b2b_bitout%0d: got %b expected %b", i, bitout, pat[i]); end
        end
        sample = 1'b0;
        tick();
        nvec++; if (actvout !== 1'b0) begin nerr++; $display("FAIL b2b_idle: got %b expected 0", actvout); end
        nvec++; if (bitcnt !== 7'd3) begin nerr++; $display("FAIL b2b_bitcnt: got %0d expected 3", bitcnt); end
    endtask

    task automatic test_saturate();
        clear_hist();
        for (int i = 0; i < 127; i++) send(logic'(i % 2));
        nvec++; if (bitcnt !== 7'd127) begin nerr++; $display("FAIL sat_127: got %0d expected 127", bitcnt); end
        send(1'b1);
        nvec++; if (actvout !== 1'b1) begin nerr++; $display("FAIL sat_actv: got %b expected 1", actvout); end
        nvec++; if (bitcnt !== 7'd127) begin nerr++; $display("FAIL sat_128: got %0d expected 127", bitcnt); end
    endtask

    task automatic test_reset_with_sample();
        clear_hist();
        for (int i = 0; i < 4; i++) send(1'b0);
        reset  = 1'b1;
        sample = 1'b1;
        rxbit  = 1'b0;
        tick();
        reset  = 1'b0;
        sample = 1'b0;
        nvec++; if (actvout !== 1'b0 || stuffbit !== 1'b0) begin nerr++; $display("FAIL rstsmp_strobes: got actv=%b stuff=%b expected 0 0", actvout, stuffbit); end
        nvec++; if (bitout !== 1'b1 || bitcnt !== 7'd0 || stufferr !== 1'b0) begin nerr++; $display("FAIL rstsmp_state: got bitout=%b cnt=%0d err=%b expected 1 0 0", bitout, bitcnt, stufferr); end
        // run history must be gone: five more zeros are all data bits
        for (int i = 0; i < 5; i++) begin
            send(1'b0);
            nvec++; if (actvout !== 1'b1) begin nerr++; $display("FAIL rstsmp_run bit%0d: got %b expected 1", i + 1, actvout); end
        end
    endtask

    task automatic test_enable_edges();
        clear_hist();
        send(1'b1);
        send(1'b1);
        destuff_en = 1'b0;
        sample = 1'b1;
        rxbit  = 1'b0;
        tick();
        sample = 1'b0;
        nvec++; if (actvout !== 1'b0) begin nerr++; $display("FAIL fall_actv: got %b expected 0", actvout); end
        nvec++; if (bitcnt !== 7'd0) begin nerr++; $display("FAIL fall_bitcnt: got %0d expected 0", bitcnt); end
        nvec++; if (bitout !== 1'b1) begin nerr++; $display("FAIL fall_bitout: got %b expected 1", bitout); end
        destuff_en = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b1);
        destuff_en = 1'b0;
        tick();
        destuff_en = 1'b1;
        send(1'b1);
        nvec++; if (actvout !== 1'b1 || bitcnt !== 7'd1) begin nerr++; $display("FAIL rise_sample: got actv=%b cnt=%0d expected 1 1", actvout, bitcnt); end
        for (int i = 0; i < 4; i++) send(1'b1);
        nvec++; if (actvout !== 1'b1 || stufferr !== 1'b0) begin nerr++; $display("FAIL rise_run5: got actv=%b err=%b expected 1 0", actvout, stufferr); end
        send(1'b1);
        nvec++; if (stufferr !== 1'b1) begin nerr++; $display("FAIL rise_err: got %b expected 1", stufferr); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        reset = 1'b1;
        sample = 1'b0;
        rxbit = 1'b1;
        destuff_en = 1'b0;
        test_reset();
        test_stuff_removal();
        test_stuff_error();
        test_chained();
        test_back_to_back();
        test_saturate();
        test_reset_with_sample();
        test_enable_edges();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
